vga_frame_writer: RTL and testbench

// - Write side of the 256x256x3-bit video memory that the VGA controller scans out.
// - Accepts drawing commands (plot pixel, fill rectangle, clear screen) over a valid/ready handshake.
// - Emits one RAM write per cycle in raster order, address = {y,x}.
// - Optional gating holds writes until vertical blank, so scan-out never shows partial frames.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_rect_scanner.sv | 81 ++++++++
 rtl/vga_frame_writer.sv | 134 +++++++++++++
 tb/tb_vga_frame_writer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA block: coordinate/colour widths, drawing
// opcodes and the frame writer FSM state encodings. The scan-out controller
// imports this package too, so widths stay consistent across both sides of
// the video memory.
package vga_pkg;

   localparam int VGA_COORD_W = 8;
   localparam int VGA_COLOR_W = 3;
   localparam int VGA_ADDR_W  = 2 * VGA_COORD_W;

   // Drawing command opcodes
   localparam logic [1:0] OP_PLOT  = 2'd0;
   localparam logic [1:0] OP_FILL  = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;
   localparam logic [1:0] OP_NOP   = 2'd3;

   // Frame writer FSM encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DRAW = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/vga_rect_scanner.sv
// Rectangle bounds registers plus a raster-order cursor stepper.
// Ports:
//   Clock, Reset          clock, async active-low reset
//   iLoad                 capture bounds and place cursor at (xmin,ymin)
//   iXMin..iYMax          normalized rectangle bounds (used on iLoad)
//   iAdvance              step the cursor one pixel in raster order
//   oX, oY                current cursor
//   oLast                 cursor sits on (xmax,ymax)
module vga_rect_scanner
   import vga_pkg::*;
#(
   parameter int COORD_W = VGA_COORD_W
)
(
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iLoad,
   input  logic [COORD_W-1:0] iXMin,
   input  logic [COORD_W-1:0] iXMax,
   input  logic [COORD_W-1:0] iYMin,
   input  logic [COORD_W-1:0] iYMax,
   input  logic               iAdvance,
   output logic [COORD_W-1:0] oX,
   output logic [COORD_W-1:0] oY,
   output logic               oLast
);

   logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
   logic [COORD_W-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
   logic [COORD_W-1:0] x_q, y_q, x_d, y_d;

   // End of rectangle is found by comparison so a full-screen scan stops at
   // (max,max) instead of relying on the counters wrapping.
   assign oLast = (x_q == xmax_q) && (y_q == ymax_q);
   assign oX    = x_q;
   assign oY    = y_q;

   always_comb begin
      xmin_d = xmin_q;
      xmax_d = xmax_q;
      ymin_d = ymin_q;
      ymax_d = ymax_q;
      x_d    = x_q;
      y_d    = y_q;
      if (iLoad) begin
         xmin_d = iXMin;
         xmax_d = iXMax;
         ymin_d = iYMin;
         ymax_d = iYMax;
         x_d    = iXMin;
         y_d    = iYMin;
      end else if (iAdvance && !oLast) begin
         // The cursor never moves past the last pixel; it holds there.
         if (x_q == xmax_q) begin
            x_d = xmin_q;
            y_d = y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         xmin_q <= '0;
         xmax_q <= '0;
         ymin_q <= '0;
         ymax_q <= '0;
         x_q    <= '0;
         y_q    <= '0;
      end else begin
         xmin_q <= xmin_d;
         xmax_q <= xmax_d;
         ymin_q <= ymin_d;
         ymax_q <= ymax_d;
         x_q    <= x_d;
         y_q    <= y_d;
      end
   end

endmodule

// File: rtl/vga_frame_writer.sv
// Write side of the 256x256x3 video memory. Accepts PLOT/FILL/CLEAR/NOP
// commands and emits one RAM write per cycle in raster order, address {y,x}.
// With VBLANK_GATE=1 writes only happen while iVBlank is high.
// Ports:
//   Clock, Reset                 clock, async active-low reset
//   iCmdValid / oCmdReady        command handshake (ready only in IDLE)
//   iCmdOp, iX0, iY0, iX1, iY1   opcode and corners
//   iColor                       pixel value
//   iVBlank                      vertical blank (used when VBLANK_GATE=1)
//   oWriteEnable/Address/Data    RAM write port
//   oBusy, oDone                 status; oDone pulses once per command
//   oState                       current FSM state (debug)
// Handshake: a command transfers on a rising edge where iCmdValid and
// oCmdReady are both high; operands are sampled only at that edge, and
// iCmdValid outside IDLE is ignored (nothing is queued).
module vga_frame_writer
   import vga_pkg::*;
#(
   parameter int COORD_W     = VGA_COORD_W,
   parameter int ADDR_W      = VGA_ADDR_W,
   parameter int COLOR_W     = VGA_COLOR_W,
   parameter int VBLANK_GATE = 0
)
(
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iCmdValid,
   output logic               oCmdReady,
   input  logic [1:0]         iCmdOp,
   input  logic [COORD_W-1:0] iX0,
   input  logic [COORD_W-1:0] iY0,
   input  logic [COORD_W-1:0] iX1,
   input  logic [COORD_W-1:0] iY1,
   input  logic [COLOR_W-1:0] iColor,
   input  logic               iVBlank,
   output logic               oWriteEnable,
   output logic [ADDR_W-1:0]  oWriteAddress,
   output logic [COLOR_W-1:0] oWriteData,
   output logic               oBusy,
   output logic               oDone,
   output logic [1:0]         oState
);

   logic [1:0]         state_q, state_d;
   logic [COLOR_W-1:0] color_q, color_d;
   logic [COORD_W-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
   logic [COORD_W-1:0] cur_x, cur_y;
   logic               cur_last;
   logic               handshake, load, write_ok, write_now;

   assign handshake = (state_q == ST_IDLE) && iCmdValid;
   // NOP never loads so the held address/data stay those of the last write.
   assign load      = handshake && (iCmdOp != OP_NOP);
   assign write_ok  = (VBLANK_GATE == 0) || iVBlank;
   assign write_now = (state_q == ST_DRAW) && write_ok;

   // Bound normalization for the incoming command
   always_comb begin
      xmin_c = (iX0 < iX1) ? iX0 : iX1;
      xmax_c = (iX0 < iX1) ? iX1 : iX0;
      ymin_c = (iY0 < iY1) ? iY0 : iY1;
      ymax_c = (iY0 < iY1) ? iY1 : iY0;
      case (iCmdOp)
         OP_PLOT: begin
            xmin_c = iX0;
            xmax_c = iX0;
            ymin_c = iY0;
            ymax_c = iY0;
         end
         OP_CLEAR: begin
            xmin_c = '0;
            xmax_c = '1;
            ymin_c = '0;
            ymax_c = '1;
         end
         default: ;
      endcase
   end

   vga_rect_scanner #(.COORD_W(COORD_W)) u_scanner (
      .Clock    (Clock),
      .Reset    (Reset),
      .iLoad    (load),
      .iXMin    (xmin_c),
      .iXMax    (xmax_c),
      .iYMin    (ymin_c),
      .iYMax    (ymax_c),
      .iAdvance (write_now),
      .oX       (cur_x),
      .oY       (cur_y),
      .oLast    (cur_last)
   );

   always_comb begin
      state_d = state_q;
      color_d = color_q;
      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               if (iCmdOp == OP_NOP) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DRAW;
                  color_d = iColor;
               end
            end
         end
         ST_DRAW: begin
            if (write_now && cur_last) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
      end
   end

   assign oCmdReady     = (state_q == ST_IDLE);
   assign oWriteEnable  = write_now;
   assign oWriteAddress = {cur_y, cur_x};
   assign oWriteData    = color_q;
   assign oBusy         = (state_q != ST_IDLE);
   assign oDone         = (state_q == ST_DONE);
   assign oState        = state_q;

endmodule

// File: tb/tb_vga_frame_writer.sv
module tb_vga_frame_writer;
   import vga_pkg::*;

   // ---------------- clock / reset ----------------
   logic Clock = 1'b0;
   logic Reset = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- shared stimulus ----------------
   logic [1:0]  cmd_op   = OP_NOP;
   logic [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic [2:0]  color    = '0;
   logic        valid_a  = 1'b0;
   logic        valid_b  = 1'b0;
   logic        vblank_b = 1'b0;

   logic        ready_a, we_a, busy_a, done_a;
   logic [15:0] addr_a;
   logic [2:0]  data_a;
   logic [1:0]  state_a;
   logic        ready_b, we_b, busy_b, done_b;
   logic [15:0] addr_b;
   logic [2:0]  data_b;
   logic [1:0]  state_b;

   vga_frame_writer #(.VBLANK_GATE(0)) dut_a (
      .Clock(Clock), .Reset(Reset),
      .iCmdValid(valid_a), .oCmdReady(ready_a), .iCmdOp(cmd_op),
      .iX0(x0), .iY0(y0), .iX1(x1), .iY1(y1), .iColor(color),
      .iVBlank(1'b0),
      .oWriteEnable(we_a), .oWriteAddress(addr_a), .oWriteData(data_a),
      .oBusy(busy_a), .oDone(done_a), .oState(state_a)
   );

   vga_frame_writer #(.VBLANK_GATE(1)) dut_b (
      .Clock(Clock), .Reset(Reset),
      .iCmdValid(valid_b), .oCmdReady(ready_b), .iCmdOp(cmd_op),
      .iX0(x0), .iY0(y0), .iX1(x1), .iY1(y1), .iColor(color),
      .iVBlank(vblank_b),
      .oWriteEnable(we_b), .oWriteAddress(addr_b), .oWriteData(data_b),
      .oBusy(busy_b), .oDone(done_b), .oState(state_b)
   );

   // ---------------- scoreboard ----------------
   logic [18:0] exp_q[$];   // {address, data}
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- driver for the ungated instance ----------------
   task automatic run_a(input logic [1:0] op, input logic [7:0] ax0, input logic [7:0] ay0,
                        input logic [7:0] ax1, input logic [7:0] ay1, input logic [2:0] col,
                        input bit hold_valid, input int budget, input int exp_done_cyc,
                        input logic [15:0] exp_hold_addr);
      int   cyc;
      bit   got_done;
      logic [18:0] e;
      @(negedge Clock);
      check("ready_before", 32'(ready_a), 32'd1);
      cmd_op = op; x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = col;
      valid_a = 1'b1;
      @(negedge Clock);
      valid_a = hold_valid;
      // Operands change after the handshake; they must have no effect.
      x0 = ~ax0; y0 = ~ay0; x1 = ~ax1; y1 = ~ay1; color = ~col; cmd_op = OP_FILL;
      cyc = 1;
      got_done = 1'b0;
      while (!got_done && cyc <= budget) begin
         if (cyc == 1) begin
            check("busy_first", 32'(busy_a), 32'd1);
            check("ready_low_first", 32'(ready_a), 32'd0);
         end
         if (we_a) begin
            if (exp_q.size() == 0) check("extra_write", 32'(addr_a), 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               check("write", 32'({addr_a, data_a}), 32'(e));
            end
         end
         if (done_a) begin
            got_done = 1'b1;
            valid_a  = 1'b0;
            check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
            check("done_no_we", 32'(we_a), 32'd0);
            check("done_not_ready", 32'(ready_a), 32'd0);
         end else begin
            @(negedge Clock);
            cyc++;
         end
      end
      if (!got_done) check("done_timeout", 32'(cyc), 32'(exp_done_cyc));
      check("missing_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      valid_a = 1'b0;
      @(negedge Clock);
      check("ready_after", 32'(ready_a), 32'd1);
      check("done_one_cycle", 32'(done_a), 32'd0);
      check("addr_hold", 32'(addr_a), 32'(exp_hold_addr));
   endtask

   // ---------------- main sequence ----------------
   logic vb_pat [0:6];
   logic exp_we [0:6];
   logic [15:0] exp_addr_b [0:6];

   initial begin
      // Reset state
      repeat (2) @(negedge Clock);
      check("rst_ready",  32'(ready_a), 32'd1);
      check("rst_we",     32'(we_a),    32'd0);
      check("rst_addr",   32'(addr_a),  32'd0);
      check("rst_data",   32'(data_a),  32'd0);
      check("rst_busy",   32'(busy_a),  32'd0);
      check("rst_done",   32'(done_a),  32'd0);
      check("rst_state",  32'(state_a), 32'(ST_IDLE));
      check("rst_ready_b", 32'(ready_b), 32'd1);
      Reset = 1'b1;
      repeat (2) @(negedge Clock);

      // PLOT (10,20) colour 5
      exp_q.push_back({16'h140A, 3'd5});
      run_a(OP_PLOT, 8'd10, 8'd20, 8'd0, 8'd0, 3'd5, 1'b0, 10, 2, 16'h140A);

      // FILL with swapped corners, iCmdValid held high while drawing
      exp_q.push_back({16'h0103, 3'd2});
      exp_q.push_back({16'h0104, 3'd2});
      exp_q.push_back({16'h0105, 3'd2});
      exp_q.push_back({16'h0203, 3'd2});
      exp_q.push_back({16'h0204, 3'd2});
      exp_q.push_back({16'h0205, 3'd2});
      run_a(OP_FILL, 8'd5, 8'd2, 8'd3, 8'd1, 3'd2, 1'b1, 20, 7, 16'h0205);

      // NOP: no writes, address keeps the last written value
      run_a(OP_NOP, 8'd7, 8'd7, 8'd9, 8'd9, 3'd4, 1'b0, 5, 1, 16'h0205);

      // FILL one row touching the right edge
      for (int i = 250; i <= 255; i++) exp_q.push_back({8'd7, 8'(i), 3'd6});
      run_a(OP_FILL, 8'd255, 8'd7, 8'd250, 8'd7, 3'd6, 1'b0, 20, 7, 16'h07FF);

      // PLOT bottom-right corner
      exp_q.push_back({16'hFFFF, 3'd7});
      run_a(OP_PLOT, 8'd255, 8'd255, 8'd3, 8'd3, 3'd7, 1'b0, 10, 2, 16'hFFFF);

      // CLEAR: full screen, ends at 0xFFFF without wrapping
      for (int i = 0; i < 65536; i++) exp_q.push_back({16'(i), 3'd0});
      run_a(OP_CLEAR, 8'd9, 8'd9, 8'd1, 8'd1, 3'd0, 1'b0, 70000, 65537, 16'hFFFF);

      // Gated instance: FILL 2x2 at origin, iVBlank 1,0,0,1,1,1
      vb_pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_we     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_addr_b = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0100, 16'h0101, 16'h0000};
      @(negedge Clock);
      vblank_b = 1'b0;
      cmd_op = OP_FILL; x0 = 8'd1; y0 = 8'd1; x1 = 8'd0; y1 = 8'd0; color = 3'd6;
      valid_b = 1'b1;
      @(negedge Clock);
      valid_b = 1'b0;
      for (int c = 0; c < 7; c++) begin
         vblank_b = vb_pat[c];
         #1;
         check("gate_we", 32'(we_b), 32'(exp_we[c]));
         if (exp_we[c]) check("gate_write", 32'({addr_b, data_b}), 32'({exp_addr_b[c], 3'd6}));
         if (c == 6) check("gate_done", 32'(done_b), 32'd1);
         else        check("gate_not_done", 32'(done_b), 32'd0);
         @(negedge Clock);
      end
      vblank_b = 1'b0;
      check("gate_ready_after", 32'(ready_b), 32'd1);

      // Reset during the third write of a FILL
      cmd_op = OP_FILL; x0 = 8'd0; y0 = 8'd0; x1 = 8'd2; y1 = 8'd1; color = 3'd1;
      valid_a = 1'b1;
      @(negedge Clock);
      valid_a = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      check("rst_mid_pre_we", 32'(we_a), 32'd1);
      check("rst_mid_pre_addr", 32'(addr_a), 32'h0002);
      Reset = 1'b0;
      #1;
      check("rst_mid_we", 32'(we_a), 32'd0);
      check("rst_mid_ready", 32'(ready_a), 32'd1);
      check("rst_mid_state", 32'(state_a), 32'(ST_IDLE));
      check("rst_mid_addr", 32'(addr_a), 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clock);
         check("rst_after_we", 32'(we_a), 32'd0);
         check("rst_after_ready", 32'(ready_a), 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
